// File: rtl/div_iter_if.sv
// Request/result bundle between the execution core (master) and the iterative divider (slave).
// The core drives the operands and start; the divider returns status and results.
interface div_iter_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_iter.sv
// Restoring radix-2 divider producing one quotient bit per clock, with signed/unsigned modes
// and single-cycle fast paths for divide-by-zero and signed MIN / -1 overflow.
module div_iter #(
   parameter int WIDTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   div_iter_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remd;
   logic             r_dbz;

   logic             w_busy;
   logic             w_done;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_b_zero;
   logic             w_ovf;
   logic             w_fast;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_ge;

   // Operand decode, only meaningful while start is sampled in IDLE
   assign w_a_neg  = bus.is_signed & bus.a[WIDTH-1];
   assign w_b_neg  = bus.is_signed & bus.b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
   assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;
   assign w_b_zero = (bus.b == '0);
   assign w_ovf    = bus.is_signed && (bus.a == MIN_VAL) && (bus.b == '1);
   assign w_fast   = w_b_zero | w_ovf;

   // Trial subtraction; the extra top bit is the borrow so no magnitude bit is lost
   assign w_shift = {r_rem, r_dvd[WIDTH-1]};
   assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
   assign w_ge    = ~w_diff[WIDTH+1];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_next = w_fast ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_next = S_FIXUP;
            end
         end
         S_FIXUP: w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_CALC:  w_busy = 1'b1;
         S_FIXUP: w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_quot  <= '0;
         r_remd  <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_dvd   <= w_a_mag;
                  r_dvs   <= w_b_mag;
                  r_rem   <= '0;
                  r_cnt   <= CNT_W'(WIDTH);
                  // Fast paths load the results directly on entry to DONE
                  if (w_b_zero) begin
                     r_quot <= '0;
                     r_remd <= bus.a;
                     r_dbz  <= 1'b1;
                  end else if (w_ovf) begin
                     r_quot <= bus.a;
                     r_remd <= '0;
                     r_dbz  <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
               r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
            end
            S_FIXUP: begin
               r_quot <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
               r_remd <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
               r_dbz  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_remd;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: 64- and 32-bit instances against a cycle-level arithmetic reference,
// plus directed literal cases for the signed, zero-divisor, overflow and control scenarios.
module tb_div_iter;
   typedef struct packed {
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
      logic        fast;
   } res_t;

   logic        clk;
   logic        rst;
   logic        drv_start [2];
   logic        drv_sgn   [2];
   logic [63:0] drv_a     [2];
   logic [63:0] drv_b     [2];
   logic        o_busy    [2];
   logic        o_done    [2];
   logic [63:0] o_q       [2];
   logic [63:0] o_r       [2];
   logic        o_dz      [2];

   int n_total = 0;
   int n_pass  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   div_iter_if #(.WIDTH(64)) if64 ();
   div_iter_if #(.WIDTH(32)) if32 ();

   div_iter #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(if64));
   div_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

   assign if64.start     = drv_start[0];
   assign if64.is_signed = drv_sgn[0];
   assign if64.a         = drv_a[0];
   assign if64.b         = drv_b[0];
   assign if32.start     = drv_start[1];
   assign if32.is_signed = drv_sgn[1];
   assign if32.a         = drv_a[1][31:0];
   assign if32.b         = drv_b[1][31:0];

   assign o_busy[0] = if64.busy;
   assign o_done[0] = if64.done;
   assign o_q[0]    = if64.quotient;
   assign o_r[0]    = if64.remainder;
   assign o_dz[0]   = if64.div_by_zero;
   assign o_busy[1] = if32.busy;
   assign o_done[1] = if32.done;
   assign o_q[1]    = {32'd0, if32.quotient};
   assign o_r[1]    = {32'd0, if32.remainder};
   assign o_dz[1]   = if32.div_by_zero;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference result from plain integer arithmetic at width w
   function automatic res_t ref_div(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                    input logic s);
      logic [63:0] mask;
      logic [63:0] minv;
      logic [63:0] a;
      logic [63:0] b;
      longint      sa;
      longint      sb;
      res_t        res;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      minv = 64'd1 << (w - 1);
      a = a_in & mask;
      b = b_in & mask;
      res.dz   = 1'b0;
      res.fast = 1'b0;
      if (b == 0) begin
         res.q = 0; res.r = a; res.dz = 1'b1; res.fast = 1'b1;
      end else if (s && a == minv && b == mask) begin
         res.q = a; res.r = 0; res.fast = 1'b1;
      end else if (s) begin
         sa = $signed(a << (64 - w)) >>> (64 - w);
         sb = $signed(b << (64 - w)) >>> (64 - w);
         res.q = 64'(sa / sb) & mask;
         res.r = 64'(sa % sb) & mask;
      end else begin
         res.q = a / b;
         res.r = a % b;
      end
      return res;
   endfunction

   function automatic logic [63:0] rnd_op(input int w);
      logic [63:0] mask;
      logic [63:0] v;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      v = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: v = 64'd0;
         1: v = '1;
         2: v = 64'd1 << (w - 1);
         3: v = 64'($urandom_range(1, 15));
         4: v = v >> $urandom_range(0, w - 1);
         default: ;
      endcase
      return v & mask;
   endfunction

   // Cycle model per instance: pending op, edges left until done, expected held outputs
   for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      localparam int W = (gi == 0) ? 64 : 32;
      res_t        w_res;
      res_t        pres;
      logic        pend  = 1'b0;
      logic        armed = 1'b0;
      int          left  = 0;
      logic [63:0] eq = '0;
      logic [63:0] er = '0;
      logic        edz = 1'b0;

      assign w_res = ref_div(W, drv_a[gi], drv_b[gi], drv_sgn[gi]);

      always @(posedge clk) begin
         if (rst) begin
            pend  <= 1'b0;
            armed <= 1'b1;
            eq    <= '0;
            er    <= '0;
            edz   <= 1'b0;
         end else if (pend) begin
            if (left == 0) begin
               pend <= 1'b0;
            end else begin
               left <= left - 1;
               if (left == 1) begin
                  eq  <= pres.q;
                  er  <= pres.r;
                  edz <= pres.dz;
               end
            end
         end else if (drv_start[gi]) begin
            pend <= 1'b1;
            pres <= w_res;
            left <= w_res.fast ? 0 : W + 1;
            if (w_res.fast) begin
               eq  <= w_res.q;
               er  <= w_res.r;
               edz <= w_res.dz;
            end
         end
      end

      always @(negedge clk) begin
         if (armed) begin
            chk($sformatf("w%0d.busy", W), 64'(o_busy[gi]), 64'(pend && left != 0));
            chk($sformatf("w%0d.done", W), 64'(o_done[gi]), 64'(pend && left == 0));
            chk($sformatf("w%0d.quotient", W), o_q[gi], eq);
            chk($sformatf("w%0d.remainder", W), o_r[gi], er);
            chk($sformatf("w%0d.div_by_zero", W), 64'(o_dz[gi]), 64'(edz));
         end
      end
   end

   // One request; poke>0 re-pulses start with junk operands at that busy cycle
   task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic s,
                         input int poke, output logic [63:0] q, output logic [63:0] r,
                         output logic dz, output int lat);
      @(negedge clk);
      drv_start[k] = 1'b1;
      drv_a[k]     = a;
      drv_b[k]     = b;
      drv_sgn[k]   = s;
      @(negedge clk);
      lat = 1;
      while (!o_done[k] && lat < 400) begin
         drv_start[k] = (lat == poke);
         drv_a[k]     = {$urandom, $urandom};
         drv_b[k]     = {$urandom, $urandom};
         drv_sgn[k]   = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      drv_start[k] = 1'b0;
      if (!o_done[k]) chk($sformatf("timeout_k%0d", k), 64'(o_done[k]), 64'd1);
      q  = o_q[k];
      r  = o_r[k];
      dz = o_dz[k];
   endtask

   task automatic op_chk(input string name, input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input int poke, input logic [63:0] eq, input logic [63:0] er,
                         input logic edz, input int elat);
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
      int          lat;
      run_op(k, a, b, s, poke, q, r, dz, lat);
      chk({name, ".q"}, q, eq);
      chk({name, ".r"}, r, er);
      chk({name, ".dz"}, 64'(dz), 64'(edz));
      chk({name, ".lat"}, 64'(lat), 64'(elat));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      res_t m;
      int   seen;
      for (int k = 0; k < 2; k++) begin
         drv_start[k] = 1'b0;
         drv_sgn[k]   = 1'b0;
         drv_a[k]     = '0;
         drv_b[k]     = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset.q", o_q[0], 64'd0);
      chk("reset.r", o_r[0], 64'd0);
      chk("reset.busy", 64'(o_busy[0]), 64'd0);
      chk("reset.done", 64'(o_done[0]), 64'd0);
      rst = 1'b0;

      m = ref_div(64, 64'd100, 64'd7, 1'b0);
      chk("model.u_q", m.q, 64'd14);
      chk("model.u_r", m.r, 64'd2);
      m = ref_div(64, -64'sd7, 64'd2, 1'b1);
      chk("model.s_q", m.q, 64'hFFFF_FFFF_FFFF_FFFD);
      m = ref_div(32, 64'hFFFF_FFF9, 64'd2, 1'b1);
      chk("model.s32_r", m.r, 64'hFFFF_FFFF);

      op_chk("u_100_7", 0, 64'd100, 64'd7, 1'b0, 0, 64'd14, 64'd2, 1'b0, 66);
      op_chk("dbz", 0, 64'hDEAD_BEEF, 64'd0, 1'b0, 0, 64'd0, 64'hDEAD_BEEF, 1'b1, 1);
      op_chk("s_m7_2", 0, -64'sd7, 64'd2, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFD, '1, 1'b0, 66);
      op_chk("s_7_m2", 0, 64'd7, -64'sd2, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 66);
      op_chk("u_m7_2", 0, -64'sd7, 64'd2, 1'b0, 0, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 1'b0, 66);
      op_chk("s_ovf", 0, 64'h8000_0000_0000_0000, '1, 1'b1, 0, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1);
      op_chk("u_max_1", 0, '1, 64'd1, 1'b0, 0, '1, 64'd0, 1'b0, 66);
      op_chk("u_5_9", 0, 64'd5, 64'd9, 1'b0, 0, 64'd0, 64'd5, 1'b0, 66);
      op_chk("s_dbz", 0, -64'sd5, 64'd0, 1'b1, 0, 64'd0, -64'sd5, 1'b1, 1);
      op_chk("poke10", 0, 64'd100, 64'd7, 1'b0, 10, 64'd14, 64'd2, 1'b0, 66);
      op_chk("w32_u", 1, 64'd100, 64'd7, 1'b0, 0, 64'd14, 64'd2, 1'b0, 34);
      op_chk("w32_ovf", 1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 0, 64'h8000_0000, 64'd0, 1'b0, 1);
      op_chk("w32_s", 1, 64'hFFFF_FFF9, 64'd2, 1'b1, 0, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 1'b0, 34);

      // Reset in the middle of a busy operation
      @(negedge clk);
      drv_start[0] = 1'b1; drv_a[0] = 64'd1000; drv_b[0] = 64'd3; drv_sgn[0] = 1'b0;
      @(negedge clk);
      drv_start[0] = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.busy", 64'(o_busy[0]), 64'd0);
      chk("midrst.q", o_q[0], 64'd0);
      chk("midrst.r", o_r[0], 64'd0);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (o_done[0]) seen++;
      end
      chk("midrst.no_done", 64'(seen), 64'd0);

      fork
         begin
            logic [63:0] q, r;
            logic        dz;
            int          lat;
            for (int i = 0; i < 600; i++) begin
               run_op(0, rnd_op(64), rnd_op(64), 1'(i >= 300),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0, q, r, dz, lat);
            end
         end
         begin
            logic [63:0] q, r;
            logic        dz;
            int          lat;
            for (int i = 0; i < 1200; i++) begin
               run_op(1, rnd_op(32), rnd_op(32), 1'(i >= 600),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0, q, r, dz, lat);
            end
         end
      join

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
